// File: rtl/cancelas_pkg.sv
// Shared constants and types for the parking-lot gate controller.
package cancelas_pkg;

  localparam int unsigned NUM_VAGAS = 8;
  localparam int unsigned IDX_W     = $clog2(NUM_VAGAS);
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ABRE_ENTRADA = 2'd1,
    ABRE_SAIDA   = 2'd2
  } estado_e;

  localparam logic PRIO_SAIDA   = 1'b0;
  localparam logic PRIO_ENTRADA = 1'b1;

endpackage

// File: rtl/controlador_cancelas_if.sv
// Request, sensor and status signals between the gate controller and its environment.
interface controlador_cancelas_if;
  import cancelas_pkg::*;

  logic                 ReqEntrada;
  logic                 ReqSaida;
  logic [IDX_W-1:0]     VagaSaida;
  logic                 PassouEntrada;
  logic                 PassouSaida;
  logic [NUM_VAGAS-1:0] Vagas;
  logic                 CancelaEntrada;
  logic                 CancelaSaida;
  logic [IDX_W-1:0]     VagaAtribuida;
  logic                 Lotado;
  logic                 ErroSaida;

  modport master (
    output ReqEntrada, ReqSaida, VagaSaida, PassouEntrada, PassouSaida,
    input  Vagas, CancelaEntrada, CancelaSaida, VagaAtribuida, Lotado, ErroSaida
  );

  modport slave (
    input  ReqEntrada, ReqSaida, VagaSaida, PassouEntrada, PassouSaida,
    output Vagas, CancelaEntrada, CancelaSaida, VagaAtribuida, Lotado, ErroSaida
  );

endinterface

// File: rtl/controlador_cancelas_codificador_vaga_livre.sv
// Lowest-index priority encoder over the free-spot map.
module codificador_vaga_livre
  import cancelas_pkg::*;
(
  input  logic [NUM_VAGAS-1:0] livres_i,
  output logic [IDX_W-1:0]     indice_c_o,
  output logic                 valido_c_o
);

  // Scan from the top so the lowest free index wins.
  always_comb begin
    indice_c_o = '0;
    valido_c_o = 1'b0;
    for (int i = NUM_VAGAS - 1; i >= 0; i--) begin
      if (livres_i[i]) begin
        indice_c_o = IDX_W'(i);
        valido_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_cancelas.sv
// Entry/exit gate controller: latches requests, arbitrates with alternating
// priority, tracks the occupancy map and auto-closes idle gates.
module controlador_cancelas
  import cancelas_pkg::*;
#(
  parameter int unsigned TEMPO_ABERTA = 250
) (
  input  logic Clock,
  input  logic ResetN,
  controlador_cancelas_if.slave bus
);

  estado_e              estado_q, estado_d;
  logic [NUM_VAGAS-1:0] vagas_q, vagas_d;
  logic                 cancela_e_q, cancela_e_d;
  logic                 cancela_s_q, cancela_s_d;
  logic                 erro_q, erro_d;
  logic                 lotado_q, lotado_d;
  logic                 pend_e_q, pend_e_d;
  logic                 pend_s_q, pend_s_d;
  logic                 prio_q, prio_d;
  logic [IDX_W-1:0]     vaga_atr_q, vaga_atr_d;
  logic [IDX_W-1:0]     vaga_s_q, vaga_s_d;
  logic [IDX_W-1:0]     vaga_sai_q, vaga_sai_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0]     livre_idx_c;
  logic                 livre_ok_c;
  logic                 pode_e_c, sel_s_c, sel_e_c;

  codificador_vaga_livre u_codificador (
    .livres_i   (~vagas_q),
    .indice_c_o (livre_idx_c),
    .valido_c_o (livre_ok_c)
  );

  // vaga_sai_q holds the spot of the exit in progress so a new ReqSaida
  // latched while the exit gate is open cannot redirect the passage.
  always_comb begin
    estado_d    = estado_q;
    vagas_d     = vagas_q;
    cancela_e_d = cancela_e_q;
    cancela_s_d = cancela_s_q;
    erro_d      = 1'b0;
    pend_e_d    = pend_e_q;
    pend_s_d    = pend_s_q;
    prio_d      = prio_q;
    vaga_atr_d  = vaga_atr_q;
    vaga_s_d    = vaga_s_q;
    vaga_sai_d  = vaga_sai_q;
    cnt_d       = cnt_q;
    pode_e_c    = 1'b0;
    sel_s_c     = 1'b0;
    sel_e_c     = 1'b0;

    if (bus.ReqEntrada && !pend_e_q) pend_e_d = 1'b1;
    if (bus.ReqSaida && !pend_s_q) begin
      pend_s_d = 1'b1;
      vaga_s_d = bus.VagaSaida;
    end

    case (estado_q)
      OCIOSO: begin
        pode_e_c = pend_e_q && livre_ok_c;
        sel_s_c  = pend_s_q && (!pode_e_c || prio_q == PRIO_SAIDA);
        sel_e_c  = pode_e_c && !sel_s_c;
        if (sel_s_c) begin
          pend_s_d = 1'b0;
          if (vagas_q[vaga_s_q]) begin
            estado_d    = ABRE_SAIDA;
            cancela_s_d = 1'b1;
            vaga_sai_d  = vaga_s_q;
            cnt_d       = '0;
            prio_d      = ~prio_q;
          end else begin
            erro_d = 1'b1;
          end
        end else if (sel_e_c) begin
          pend_e_d    = 1'b0;
          estado_d    = ABRE_ENTRADA;
          cancela_e_d = 1'b1;
          vaga_atr_d  = livre_idx_c;
          cnt_d       = '0;
          prio_d      = ~prio_q;
        end
      end
      ABRE_ENTRADA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.PassouEntrada) begin
          vagas_d[vaga_atr_q] = 1'b1;
          cancela_e_d         = 1'b0;
          estado_d            = OCIOSO;
        end else if (cnt_q == CNT_W'(TEMPO_ABERTA - 1)) begin
          cancela_e_d = 1'b0;
          estado_d    = OCIOSO;
        end
      end
      ABRE_SAIDA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.PassouSaida) begin
          vagas_d[vaga_sai_q] = 1'b0;
          cancela_s_d         = 1'b0;
          estado_d            = OCIOSO;
        end else if (cnt_q == CNT_W'(TEMPO_ABERTA - 1)) begin
          cancela_s_d = 1'b0;
          estado_d    = OCIOSO;
        end
      end
      default: begin
        estado_d    = OCIOSO;
        cancela_e_d = 1'b0;
        cancela_s_d = 1'b0;
      end
    endcase

    lotado_d = &vagas_d;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      estado_q    <= OCIOSO;
      vagas_q     <= '0;
      cancela_e_q <= 1'b0;
      cancela_s_q <= 1'b0;
      erro_q      <= 1'b0;
      lotado_q    <= 1'b0;
      pend_e_q    <= 1'b0;
      pend_s_q    <= 1'b0;
      prio_q      <= PRIO_SAIDA;
      vaga_atr_q  <= '0;
      vaga_s_q    <= '0;
      vaga_sai_q  <= '0;
      cnt_q       <= '0;
    end else begin
      estado_q    <= estado_d;
      vagas_q     <= vagas_d;
      cancela_e_q <= cancela_e_d;
      cancela_s_q <= cancela_s_d;
      erro_q      <= erro_d;
      lotado_q    <= lotado_d;
      pend_e_q    <= pend_e_d;
      pend_s_q    <= pend_s_d;
      prio_q      <= prio_d;
      vaga_atr_q  <= vaga_atr_d;
      vaga_s_q    <= vaga_s_d;
      vaga_sai_q  <= vaga_sai_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.Vagas          = vagas_q;
  assign bus.CancelaEntrada = cancela_e_q;
  assign bus.CancelaSaida   = cancela_s_q;
  assign bus.VagaAtribuida  = vaga_atr_q;
  assign bus.Lotado         = lotado_q;
  assign bus.ErroSaida      = erro_q;

endmodule

// File: tb/tb_controlador_cancelas.sv
// Directed self-checking bench for controlador_cancelas.
module tb_controlador_cancelas;
  import cancelas_pkg::*;

  localparam int unsigned TEMPO = 12;

  logic Clock;
  logic ResetN;
  int   n_checks;
  int   n_erros;

  controlador_cancelas_if bus ();

  controlador_cancelas #(.TEMPO_ABERTA(TEMPO)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulsa_req_e();
    bus.ReqEntrada = 1'b1;
    tick();
    bus.ReqEntrada = 1'b0;
  endtask

  task automatic pulsa_req_s(input logic [2:0] vaga);
    bus.VagaSaida = vaga;
    bus.ReqSaida  = 1'b1;
    tick();
    bus.ReqSaida  = 1'b0;
  endtask

  task automatic pulsa_passou_e();
    bus.PassouEntrada = 1'b1;
    tick();
    bus.PassouEntrada = 1'b0;
  endtask

  task automatic pulsa_passou_s();
    bus.PassouSaida = 1'b1;
    tick();
    bus.PassouSaida = 1'b0;
  endtask

  task automatic entrar(input string tag, input logic [2:0] idx, input logic [7:0] vagas_esp);
    pulsa_req_e();
    tick();
    verifica({tag, "_aberta"}, 32'(bus.CancelaEntrada), 32'd1);
    verifica({tag, "_idx"}, 32'(bus.VagaAtribuida), 32'(idx));
    pulsa_passou_e();
    verifica({tag, "_fechada"}, 32'(bus.CancelaEntrada), 32'd0);
    verifica({tag, "_vagas"}, 32'(bus.Vagas), 32'(vagas_esp));
  endtask

  task automatic sair(input string tag, input logic [2:0] idx, input logic [7:0] vagas_esp);
    pulsa_req_s(idx);
    tick();
    verifica({tag, "_aberta"}, 32'(bus.CancelaSaida), 32'd1);
    pulsa_passou_s();
    verifica({tag, "_fechada"}, 32'(bus.CancelaSaida), 32'd0);
    verifica({tag, "_vagas"}, 32'(bus.Vagas), 32'(vagas_esp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: obtido=timeout esperado=fim");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks          = 0;
    n_erros           = 0;
    ResetN            = 1'b0;
    bus.ReqEntrada    = 1'b0;
    bus.ReqSaida      = 1'b0;
    bus.VagaSaida     = '0;
    bus.PassouEntrada = 1'b0;
    bus.PassouSaida   = 1'b0;

    // Reset state
    repeat (3) tick();
    verifica("rst_vagas", 32'(bus.Vagas), 32'h00);
    verifica("rst_cancela_e", 32'(bus.CancelaEntrada), 32'd0);
    verifica("rst_cancela_s", 32'(bus.CancelaSaida), 32'd0);
    verifica("rst_vaga_atr", 32'(bus.VagaAtribuida), 32'd0);
    verifica("rst_lotado", 32'(bus.Lotado), 32'd0);
    verifica("rst_erro", 32'(bus.ErroSaida), 32'd0);
    ResetN = 1'b1;
    tick();

    // Basic entry with passage five cycles after the request
    pulsa_req_e();
    verifica("e1_decisao", 32'(bus.CancelaEntrada), 32'd0);
    tick();
    verifica("e1_aberta", 32'(bus.CancelaEntrada), 32'd1);
    verifica("e1_idx", 32'(bus.VagaAtribuida), 32'd0);
    verifica("e1_saida_fech", 32'(bus.CancelaSaida), 32'd0);
    repeat (3) tick();
    pulsa_passou_e();
    verifica("e1_vagas", 32'(bus.Vagas), 32'h01);
    verifica("e1_fechada", 32'(bus.CancelaEntrada), 32'd0);

    // Passage in idle is ignored
    pulsa_passou_s();
    pulsa_passou_e();
    verifica("ocioso_passou", 32'(bus.Vagas), 32'h01);

    // Rejected exit of an empty spot
    pulsa_req_s(3'd5);
    verifica("err_antes", 32'(bus.ErroSaida), 32'd0);
    tick();
    verifica("err_pulso", 32'(bus.ErroSaida), 32'd1);
    verifica("err_sem_portao", 32'({bus.CancelaEntrada, bus.CancelaSaida}), 32'd0);
    tick();
    verifica("err_fim", 32'(bus.ErroSaida), 32'd0);
    verifica("err_vagas", 32'(bus.Vagas), 32'h01);

    // Timeout without passage
    pulsa_req_e();
    tick();
    verifica("to_aberta", 32'(bus.CancelaEntrada), 32'd1);
    verifica("to_idx", 32'(bus.VagaAtribuida), 32'd1);
    repeat (TEMPO - 1) tick();
    verifica("to_ainda_aberta", 32'(bus.CancelaEntrada), 32'd1);
    tick();
    verifica("to_fechada", 32'(bus.CancelaEntrada), 32'd0);
    verifica("to_vagas", 32'(bus.Vagas), 32'h01);

    // Asynchronous reset while the gate is open
    pulsa_req_e();
    tick();
    verifica("ra_aberta", 32'(bus.CancelaEntrada), 32'd1);
    #3 ResetN = 1'b0;
    #1;
    verifica("ra_fechada", 32'(bus.CancelaEntrada), 32'd0);
    verifica("ra_vagas", 32'(bus.Vagas), 32'h00);
    tick();
    ResetN = 1'b1;
    tick();

    // Build Vagas=8'h04 leaving priority at exit-first (six grants)
    entrar("f0", 3'd0, 8'h01);
    entrar("f1", 3'd1, 8'h03);
    entrar("f2", 3'd2, 8'h07);
    sair("s0", 3'd0, 8'h06);
    sair("s1", 3'd1, 8'h04);
    pulsa_req_e();
    tick();
    verifica("to2_idx", 32'(bus.VagaAtribuida), 32'd0);
    repeat (TEMPO) tick();
    verifica("to2_vagas", 32'(bus.Vagas), 32'h04);

    // Simultaneous requests: exit wins, then entry wins the next tie
    bus.VagaSaida  = 3'd2;
    bus.ReqEntrada = 1'b1;
    bus.ReqSaida   = 1'b1;
    tick();
    bus.ReqEntrada = 1'b0;
    bus.ReqSaida   = 1'b0;
    tick();
    verifica("tie1_saida", 32'(bus.CancelaSaida), 32'd1);
    verifica("tie1_entrada", 32'(bus.CancelaEntrada), 32'd0);
    pulsa_req_s(3'd2);
    pulsa_passou_e();
    verifica("tie1_passou_outro", 32'(bus.Vagas), 32'h04);
    verifica("tie1_ainda_aberta", 32'(bus.CancelaSaida), 32'd1);
    pulsa_passou_s();
    verifica("tie1_vagas", 32'(bus.Vagas), 32'h00);
    verifica("tie1_fechada", 32'(bus.CancelaSaida), 32'd0);
    tick();
    verifica("tie2_entrada", 32'(bus.CancelaEntrada), 32'd1);
    verifica("tie2_saida", 32'(bus.CancelaSaida), 32'd0);
    verifica("tie2_idx", 32'(bus.VagaAtribuida), 32'd0);
    pulsa_passou_e();
    verifica("tie2_vagas", 32'(bus.Vagas), 32'h01);
    tick();
    verifica("tie3_erro", 32'(bus.ErroSaida), 32'd1);

    // Full lot: entry waits until a spot frees
    entrar("c1", 3'd1, 8'h03);
    entrar("c2", 3'd2, 8'h07);
    entrar("c3", 3'd3, 8'h0F);
    entrar("c4", 3'd4, 8'h1F);
    entrar("c5", 3'd5, 8'h3F);
    entrar("c6", 3'd6, 8'h7F);
    entrar("c7", 3'd7, 8'hFF);
    verifica("cheio_lotado", 32'(bus.Lotado), 32'd1);
    pulsa_req_e();
    repeat (3) tick();
    verifica("cheio_sem_portao", 32'(bus.CancelaEntrada), 32'd0);
    pulsa_req_s(3'd3);
    tick();
    verifica("cheio_saida", 32'(bus.CancelaSaida), 32'd1);
    pulsa_passou_s();
    verifica("cheio_vagas", 32'(bus.Vagas), 32'hF7);
    verifica("cheio_lotado0", 32'(bus.Lotado), 32'd0);
    tick();
    verifica("cheio_entrada", 32'(bus.CancelaEntrada), 32'd1);
    verifica("cheio_idx", 32'(bus.VagaAtribuida), 32'd3);
    pulsa_passou_e();
    verifica("cheio_final", 32'(bus.Vagas), 32'hFF);
    verifica("cheio_lotado1", 32'(bus.Lotado), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
    $finish;
  end

endmodule

// File: doc/controlador_cancelas.md
CONTROLADOR_CANCELAS -- requirements
Module: controlador_cancelas

Interface
REQ-001 SHALL have parameter TEMPO_ABERTA, default 250, the number of cycles a gate stays open without a passage before it auto-closes.
REQ-002 SHALL have port Clock  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port ResetN  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ReqEntrada  input  1  single-cycle pulse: a car is requesting entry.
REQ-005 SHALL have port ReqSaida  input  1  single-cycle pulse: a car is requesting exit.
REQ-006 SHALL have port VagaSaida  input  3  index of the spot being vacated, sampled on the ReqSaida pulse.
REQ-007 SHALL have port PassouEntrada  input  1  pulse: the entry-gate sensor detected a passage.
REQ-008 SHALL have port PassouSaida  input  1  pulse: the exit-gate sensor detected a passage.
REQ-009 SHALL have port Vagas  output  8  occupancy map; bit i = 1 means spot i is occupied.
REQ-010 SHALL have port CancelaEntrada  output  1  entry gate open.
REQ-011 SHALL have port CancelaSaida  output  1  exit gate open.
REQ-012 SHALL have port VagaAtribuida  output  3  spot assigned to the current entering car.
REQ-013 SHALL have port Lotado  output  1  high when all 8 bits of Vagas are 1.
REQ-014 SHALL have port ErroSaida  output  1  one-cycle pulse when an exit request is rejected.

Function
REQ-015 SHALL latch ReqEntrada and ReqSaida into pending flags PendE and PendS, together with VagaSaida into VagaS; a new pulse while a flag is already set is ignored.
REQ-016 SHALL implement the FSM states OCIOSO, ABRE_ENTRADA and ABRE_SAIDA.
REQ-017 In OCIOSO, SHALL grant at most one pending request per cycle; the state, gate output and VagaAtribuida register on the next edge, so the gate opens 1 cycle after the grant decision.
REQ-018 Arbitration SHALL be alternating priority: the bit Prio selects the preferred side on a tie and flips after every grant; Prio resets to exit-first.
REQ-019 An entry SHALL be grantable only when Lotado=0; while Lotado=1, PendE stays set and is served once a spot frees.
REQ-020 On an entry grant, VagaAtribuida SHALL take the lowest-index zero bit of Vagas and PendE SHALL clear.
REQ-021 On an exit request where Vagas[VagaS]=0, the request SHALL be rejected: ErroSaida pulses for 1 cycle, PendS clears, and the state stays OCIOSO.
REQ-022 In ABRE_ENTRADA, a PassouEntrada pulse SHALL set Vagas[VagaAtribuida] on the next edge, drop CancelaEntrada and return to OCIOSO.
REQ-023 In ABRE_SAIDA, a PassouSaida pulse SHALL clear Vagas[VagaS] on the next edge, drop CancelaSaida and return to OCIOSO.
REQ-024 The timeout counter SHALL clear on entry to an ABRE_* state; after TEMPO_ABERTA cycles with no passage, the gate SHALL close, Vagas SHALL be unchanged, and the state returns to OCIOSO.
REQ-025 A passage pulse on the non-active gate, or any passage pulse in OCIOSO, SHALL be ignored.
REQ-026 Requests arriving while a gate is open SHALL stay pending and be arbitrated in the first OCIOSO cycle.
REQ-027 The two gates SHALL never be open at the same time.

Reset
REQ-028 While ResetN=0, the block SHALL force: state OCIOSO, Vagas=0, both gates closed, VagaAtribuida=0, ErroSaida=0, PendE=PendS=0, VagaS=0, counter=0, Prio=exit-first.
REQ-029 Reset asserted while a gate is open SHALL close the gate immediately and discard the passage in progress; the car is not counted.

Structure
REQ-030 The shared package cancelas_pkg SHALL hold NUM_VAGAS=8, the FSM state enum and the counter-width constant.
REQ-031 The lowest-free-spot search SHALL be the sub-module codificador_vaga_livre (8-bit in -> 3-bit index + valid).

Verification
REQ-032 Reset, then ReqEntrada, then PassouEntrada 5 cycles later -> CancelaEntrada high 1 cycle after the request is granted, VagaAtribuida=0, Vagas=8'h01 after the passage, gate closed.
REQ-033 Vagas=8'hFF, ReqEntrada -> Lotado=1 and no gate opens; then exit of spot 3 with passage -> Vagas=8'hF7, then the pending entry opens with VagaAtribuida=3.
REQ-034 ReqEntrada and ReqSaida(VagaSaida=2, Vagas=8'h04) in the same cycle after reset -> exit is served first (CancelaSaida), then entry; the next tie goes to entry.
REQ-035 ReqSaida with VagaSaida=5 while Vagas=8'h01 -> ErroSaida pulses 1 cycle, no gate opens, Vagas unchanged.
REQ-036 Entry granted, no PassouEntrada -> CancelaEntrada falls after exactly TEMPO_ABERTA cycles, Vagas unchanged; ResetN pulsed low mid-open -> gate low asynchronously, Vagas=0.
